// File: rtl/bg_trim_pkg.sv
// Shared types and constants for the bandgap trim sequencer.
// Optional chopped comparator sampling is selected with BG_TRIM_CHOP_EN (see bg_trim_ctrl).
package bg_trim_pkg;

  localparam int SAR_W = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWRUP,
    ST_ZERO,
    ST_COARSE,
    ST_FINE,
    ST_DONE
  } state_e;

  // Values every bgCore control takes while the sequencer is OFF or in reset
  localparam logic             RST_PWRUP          = 1'b0;
  localparam logic             RST_RESET          = 1'b1;
  localparam logic [SAR_W-1:0] RST_CODE           = '0;
  localparam logic [3:0]       RST_IDAC_OUT_SEL_N = 4'hF;
  localparam logic [7:0]       RST_DIODE_SEL      = 8'h00;
  localparam logic             RST_RES_STABLE     = 1'b0;
  localparam logic             RST_RES_PTAT_EN_N  = 1'b1;
  localparam logic             RST_DIODE          = 1'b0;
  localparam logic             RST_BIG_DIODE_RES  = 1'b0;
  localparam logic             RST_CMP_ZERO       = 1'b0;
  localparam logic             RST_CMP_SWAP       = 1'b0;

  function automatic logic code_saturated(input logic [SAR_W-1:0] code);
    return (code == '0) || (code == '1);
  endfunction

endpackage

// File: rtl/bg_trim_ctrl_if.sv
// Control/trim bus between the trim sequencer (master) and bgCore plus its host (slave).
interface bg_trim_ctrl_if;
  import bg_trim_pkg::*;

  logic             enable;
  logic             start;
  logic [7:0]       cfgDiodeSelect;
  logic [3:0]       cfgIdacOutSel_n;
  logic             cfgBigDiodeRes;
  logic             cmpo;

  logic             pwrup;
  logic             reset;
  logic [SAR_W-1:0] idacCoarse;
  logic [SAR_W-1:0] idacFine;
  logic [3:0]       idacOutSelect_n;
  logic [7:0]       diodeSelect;
  logic             resStableSelect;
  logic             resPtatEnable_n;
  logic             diode;
  logic             bigDiodeRes;
  logic             cmpZeroOffset;
  logic             cmpSwapInput;
  logic             busy;
  logic             done;
  logic             sat;

  modport master (
    input  enable, start, cfgDiodeSelect, cfgIdacOutSel_n, cfgBigDiodeRes, cmpo,
    output pwrup, reset, idacCoarse, idacFine, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, diode, bigDiodeRes, cmpZeroOffset,
           cmpSwapInput, busy, done, sat
  );

  modport slave (
    output enable, start, cfgDiodeSelect, cfgIdacOutSel_n, cfgBigDiodeRes, cmpo,
    input  pwrup, reset, idacCoarse, idacFine, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, diode, bigDiodeRes, cmpZeroOffset,
           cmpSwapInput, busy, done, sat
  );
endinterface

// File: rtl/bg_sar_reg.sv
// Successive-approximation code register: MSB-first trial/decide with a last-bit flag.
module bg_sar_reg
  import bg_trim_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_init,
  input  logic             i_decide,
  input  logic             i_keep,
  output logic [SAR_W-1:0] o_code,
  output logic             o_last
);

  localparam logic [SAR_W-1:0] MSB = {1'b1, {(SAR_W-1){1'b0}}};

  logic [SAR_W-1:0] r_code;
  logic [SAR_W-1:0] r_mask;

  // r_mask is one-hot on the bit under trial; deciding resolves it and sets the next trial bit
  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_code <= '0;
      r_mask <= '0;
    end else if (i_init) begin
      r_code <= MSB;
      r_mask <= MSB;
    end else if (i_decide) begin
      r_code <= (i_keep ? r_code : (r_code & ~r_mask)) | (r_mask >> 1);
      r_mask <= r_mask >> 1;
    end
  end

  assign o_code = r_code;
  assign o_last = r_mask[0];

endmodule

// File: rtl/bg_trim_ctrl.sv
// bgCore trim sequencer: power-up, comparator auto-zero, coarse then fine SAR on CMPO.
// Define BG_TRIM_CHOP_EN to sample each SAR bit twice with the comparator inputs swapped.
module bg_trim_ctrl
  import bg_trim_pkg::*;
#(
  parameter int PWRUP_CYCLES  = 1024,
  parameter int ZERO_CYCLES   = 32,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  bg_trim_ctrl_if.master bus
);

  localparam int MAX_A   = (PWRUP_CYCLES > ZERO_CYCLES) ? PWRUP_CYCLES : ZERO_CYCLES;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] LD_PWRUP  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ZERO   = CNT_W'(ZERO_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES);

  state_e           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_val;
  logic             w_cnt_ld, w_clr, w_cfg_ld;
  logic             w_c_init, w_f_init, w_c_dec, w_f_dec;
  logic             w_keep, w_bit_end, w_sar, w_act;
  logic             r_cmpo_m, r_cmpo_s;
  logic             r_done, r_sat;
  logic [7:0]       r_cfg_ds;
  logic [3:0]       r_cfg_ios_n;
  logic             r_cfg_bdr;
  logic [SAR_W-1:0] w_c_code, w_f_code;
  logic             w_c_last, w_f_last;

  assign w_sar = (r_state == ST_COARSE) || (r_state == ST_FINE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cmpo_m <= 1'b0;
      r_cmpo_s <= 1'b0;
    end else begin
      r_cmpo_m <= bus.cmpo;
      r_cmpo_s <= r_cmpo_m;
    end
  end

`ifdef BG_TRIM_CHOP_EN
  logic r_phase, r_first;

  // phase 0 samples unswapped, phase 1 swapped; a true result must flip with the swap
  always_ff @(posedge clk) begin
    if (!reset_n || !w_sar)     r_phase <= 1'b0;
    else if (r_cnt == '0)       r_phase <= ~r_phase;
  end

  always_ff @(posedge clk) begin
    if (w_sar && (r_cnt == '0) && !r_phase) r_first <= r_cmpo_s;
  end

  assign w_bit_end        = (r_cnt == '0) && r_phase;
  assign w_keep           = r_first & ~r_cmpo_s;
  assign bus.cmpSwapInput = w_sar & r_phase;
`else
  assign w_bit_end        = (r_cnt == '0);
  assign w_keep           = r_cmpo_s;
  assign bus.cmpSwapInput = RST_CMP_SWAP;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_ld  = 1'b0;
    w_cnt_val = LD_SETTLE;
    w_clr     = 1'b0;
    w_cfg_ld  = 1'b0;
    w_c_init  = 1'b0;
    w_f_init  = 1'b0;
    w_c_dec   = 1'b0;
    w_f_dec   = 1'b0;
    unique case (r_state)
      ST_OFF: if (bus.start) begin
        w_nxt = ST_PWRUP; w_cnt_ld = 1'b1; w_cnt_val = LD_PWRUP; w_cfg_ld = 1'b1;
      end
      ST_PWRUP: if (r_cnt == '0) begin
        w_nxt = ST_ZERO; w_cnt_ld = 1'b1; w_cnt_val = LD_ZERO;
      end
      ST_ZERO: if (r_cnt == '0) begin
        w_nxt = ST_COARSE; w_cnt_ld = 1'b1; w_c_init = 1'b1;
      end
      ST_COARSE: if (r_cnt == '0) begin
        w_cnt_ld = 1'b1;
        if (w_bit_end) begin
          w_c_dec = 1'b1;
          if (w_c_last) begin
            w_nxt = ST_FINE; w_f_init = 1'b1;
          end
        end
      end
      ST_FINE: if (r_cnt == '0) begin
        w_cnt_ld = 1'b1;
        if (w_bit_end) begin
          w_f_dec = 1'b1;
          if (w_f_last) w_nxt = ST_DONE;
        end
      end
      ST_DONE: if (bus.start) begin
        w_nxt = ST_ZERO; w_cnt_ld = 1'b1; w_cnt_val = LD_ZERO; w_clr = 1'b1;
      end
      default: w_nxt = ST_OFF;
    endcase
    // enable low overrides everything, including a simultaneous start
    if (!bus.enable) begin
      w_nxt    = ST_OFF;
      w_clr    = 1'b1;
      w_cnt_ld = 1'b0;
      w_cfg_ld = 1'b0;
      w_c_init = 1'b0;
      w_f_init = 1'b0;
      w_c_dec  = 1'b0;
      w_f_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_cnt_ld)         r_cnt <= w_cnt_val;
      else if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      r_done  <= (r_state == ST_DONE) && (w_nxt == ST_DONE);
      r_sat   <= (r_state == ST_DONE) && (w_nxt == ST_DONE) && code_saturated(w_c_code);
    end
  end

  always_ff @(posedge clk) begin
    if (w_cfg_ld) begin
      r_cfg_ds    <= bus.cfgDiodeSelect;
      r_cfg_ios_n <= bus.cfgIdacOutSel_n;
      r_cfg_bdr   <= bus.cfgBigDiodeRes;
    end
  end

  bg_sar_reg u_coarse (
    .clk(clk), .reset_n(reset_n), .i_clr(w_clr), .i_init(w_c_init),
    .i_decide(w_c_dec), .i_keep(w_keep), .o_code(w_c_code), .o_last(w_c_last)
  );

  bg_sar_reg u_fine (
    .clk(clk), .reset_n(reset_n), .i_clr(w_clr), .i_init(w_f_init),
    .i_decide(w_f_dec), .i_keep(w_keep), .o_code(w_f_code), .o_last(w_f_last)
  );

  assign w_act               = (r_state != ST_OFF);
  assign bus.pwrup           = w_act ? ~RST_PWRUP         : RST_PWRUP;
  assign bus.reset           = w_act ? ~RST_RESET         : RST_RESET;
  assign bus.resStableSelect = w_act ? ~RST_RES_STABLE    : RST_RES_STABLE;
  assign bus.resPtatEnable_n = w_act ? ~RST_RES_PTAT_EN_N : RST_RES_PTAT_EN_N;
  assign bus.diode           = w_act ? ~RST_DIODE         : RST_DIODE;
  assign bus.diodeSelect     = w_act ? r_cfg_ds           : RST_DIODE_SEL;
  assign bus.idacOutSelect_n = w_act ? r_cfg_ios_n        : RST_IDAC_OUT_SEL_N;
  assign bus.bigDiodeRes     = w_act ? r_cfg_bdr          : RST_BIG_DIODE_RES;
  assign bus.cmpZeroOffset   = (r_state == ST_ZERO) ? ~RST_CMP_ZERO : RST_CMP_ZERO;
  assign bus.idacCoarse      = w_c_code;
  assign bus.idacFine        = w_f_code;
  assign bus.busy            = (r_state == ST_PWRUP) || (r_state == ST_ZERO) || w_sar;
  assign bus.done            = r_done;
  assign bus.sat             = r_sat;

endmodule
